div_ctrl: RTL

Multi-cycle divide sequencer for the EX stage. It accepts DIV/DIVU selections from the ALU decode output and runs a one-bit-per-cycle restoring divider. While the divide runs it stalls the pipeline, then delivers quotient (LO) and remainder (HI) with a single-cycle HI/LO write strobe. It sits beside the ALU in EX; the hazard unit ORs `stall_e` into the EX/earlier-stage stall, and the HI/LO register file consumes `hilo_we`, `hi_o` and `lo_o`.

---
 rtl/div_ctrl_pkg.sv | 20 ++
 rtl/div_iter.sv | 30 +++
 rtl/div_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the EX-stage divide sequencer: ALU op codes that
// select a divide, FSM state encoding and the iteration counter width.
package div_ctrl_pkg;

    // ALU control codes from decode that request a divide
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // Iteration counter width for the default 32-bit datapath
    localparam int DIV_CNT_W = 5;

    // Divide sequencer states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_ON   = 2'b01,
        DIV_ZERO = 2'b10,
        DIV_END  = 2'b11
    } div_state_e;

endpackage

// File: rtl/div_iter.sv
// One restoring-division step: shift {rem, dvd} left by one, trial-subtract
// the divisor from the widened partial remainder, keep or restore, and shift
// the resulting quotient bit into the dividend register.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] dvd,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] dvd_next
);

    logic [WIDTH:0]   partial_s;
    logic [WIDTH+1:0] diff_s;

    // Trial subtract; the extra top bit of diff_s is the borrow/sign
    always_comb begin
        partial_s = {rem, dvd[WIDTH-1]};
        diff_s    = {1'b0, partial_s} - {2'b00, divisor};
        if (diff_s[WIDTH+1] == 1'b0) begin
            rem_next = diff_s[WIDTH-1:0];
            dvd_next = {dvd[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = partial_s[WIDTH-1:0];
            dvd_next = {dvd[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle signed/unsigned divide sequencer for EX. Stalls the pipeline
// while a restoring divide runs one bit per cycle, then presents quotient on
// lo_o and remainder on hi_o with a single-cycle hilo_we strobe.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             valid_e,
    input  logic [7:0]       alucontrol,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    output logic             stall_e,
    output logic             busy,
    output logic             hilo_we,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_e       state_r;
    div_state_e       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] dvd_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] raw_opa_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             neg_q_r;
    logic             neg_r_r;

    logic             is_signed_s;
    logic             start_s;
    logic             last_iter_s;
    logic [WIDTH-1:0] abs_a_s;
    logic [WIDTH-1:0] abs_b_s;
    logic             neg_q_s;
    logic             neg_r_s;
    logic [WIDTH-1:0] rem_next_s;
    logic [WIDTH-1:0] dvd_next_s;
    logic [WIDTH-1:0] q_fix_s;
    logic [WIDTH-1:0] r_fix_s;
    logic             stall_s;
    logic             busy_s;
    logic             hilo_we_s;

    assign is_signed_s = (alucontrol == EXE_DIV_OP);
    assign start_s     = valid_e & (is_signed_s | (alucontrol == EXE_DIVU_OP)) & ~flush;
    assign last_iter_s = (cnt_r == CNT_W'(WIDTH - 1));

    div_iter #(.WIDTH(WIDTH)) u_div_iter (
        .rem      (rem_r),
        .dvd      (dvd_r),
        .divisor  (divisor_r),
        .rem_next (rem_next_s),
        .dvd_next (dvd_next_s)
    );

    // Operand magnitudes and result signs for the divide about to start
    always_comb begin
        if (is_signed_s & opa[WIDTH-1]) begin
            abs_a_s = ~opa + WIDTH'(1);
        end else begin
            abs_a_s = opa;
        end
        if (is_signed_s & opb[WIDTH-1]) begin
            abs_b_s = ~opb + WIDTH'(1);
        end else begin
            abs_b_s = opb;
        end
        neg_q_s = is_signed_s & (opa[WIDTH-1] ^ opb[WIDTH-1]);
        neg_r_s = is_signed_s & opa[WIDTH-1];
    end

    // Two's-complement sign fix-up of the final iteration's quotient/remainder
    always_comb begin
        if (neg_q_r) begin
            q_fix_s = ~dvd_next_s + WIDTH'(1);
        end else begin
            q_fix_s = dvd_next_s;
        end
        if (neg_r_r) begin
            r_fix_s = ~rem_next_s + WIDTH'(1);
        end else begin
            r_fix_s = rem_next_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; flush returns to IDLE from any state
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            DIV_IDLE: begin
                if (start_s) begin
                    if (opb == WIDTH'(0)) begin
                        next_state_s = DIV_ZERO;
                    end else begin
                        next_state_s = DIV_ON;
                    end
                end else begin
                    next_state_s = DIV_IDLE;
                end
            end
            DIV_ON: begin
                if (last_iter_s) begin
                    next_state_s = DIV_END;
                end else begin
                    next_state_s = DIV_ON;
                end
            end
            DIV_ZERO: next_state_s = DIV_END;
            DIV_END:  next_state_s = DIV_IDLE;
            default:  next_state_s = DIV_IDLE;
        endcase
        if (flush) begin
            next_state_s = DIV_IDLE;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // FSM outputs; stall is held off during reset so EX is released at once
    always_comb begin
        stall_s   = 1'b0;
        hilo_we_s = 1'b0;
        busy_s    = (state_r != DIV_IDLE);
        case (state_r)
            DIV_IDLE: stall_s = start_s;
            DIV_ON:   stall_s = ~flush;
            DIV_ZERO: stall_s = ~flush;
            DIV_END:  hilo_we_s = ~flush;
            default: begin
                stall_s   = 1'b0;
                hilo_we_s = 1'b0;
            end
        endcase
        if (!resetn) begin
            stall_s = 1'b0;
        end else begin
            stall_s = stall_s;
        end
    end

    assign stall_e = stall_s;
    assign busy    = busy_s;
    assign hilo_we = hilo_we_s;
    assign hi_o    = hi_r;
    assign lo_o    = lo_r;

    // Datapath: operand capture, iteration, counter and HI/LO result load
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_r     <= CNT_W'(0);
            rem_r     <= WIDTH'(0);
            dvd_r     <= WIDTH'(0);
            divisor_r <= WIDTH'(0);
            raw_opa_r <= WIDTH'(0);
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            hi_r      <= WIDTH'(0);
            lo_r      <= WIDTH'(0);
        end else begin
            case (state_r)
                DIV_IDLE: begin
                    if (start_s) begin
                        cnt_r     <= CNT_W'(0);
                        rem_r     <= WIDTH'(0);
                        dvd_r     <= abs_a_s;
                        divisor_r <= abs_b_s;
                        raw_opa_r <= opa;
                        neg_q_r   <= neg_q_s;
                        neg_r_r   <= neg_r_s;
                    end
                end
                DIV_ON: begin
                    if (!flush) begin
                        rem_r <= rem_next_s;
                        dvd_r <= dvd_next_s;
                        cnt_r <= cnt_r + CNT_W'(1);
                        if (last_iter_s) begin
                            hi_r  <= r_fix_s;
                            lo_r  <= q_fix_s;
                            cnt_r <= CNT_W'(0);
                        end
                    end
                end
                DIV_ZERO: begin
                    if (!flush) begin
                        lo_r <= {WIDTH{1'b1}};
                        hi_r <= raw_opa_r;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

endmodule
